trace_capture_ram: RTL and testbench

- Single-clock, parametrised trace buffer built on an inferred URAM/BRAM array with a configurable registered read latency.
- Captures a stream of sensor samples, such as power side-channel traces, into a circular buffer with pre-trigger history and post-trigger fill.
- Once the trace is complete it freezes, and the host reads it back oldest-first by relative index.
- Sits between the sensor sample pipeline and the host/readout logic.

---
 rtl/trace_capture_ram.sv | 82 ++++++++
 tb/tb_trace_capture_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_ram.sv
// trace_capture_ram: circular trace buffer with pre-trigger history, post-trigger fill and frozen oldest-first readback
module trace_capture_ram #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  trigger,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  trig_early,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t st, st_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dq [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld;
  logic [ADDR_WIDTH-1:0] wr_ptr, fill, p, start_ptr, rd_addr;
  logic [ADDR_WIDTH:0] post_rem, post_init;
  logic arm_ok, wr_en, trig_hit, trig_ok, rd_fire, post_last;
  always_comb begin
    arm_ok    = arm && (st == IDLE || (st == DONE && vld == '0));
    wr_en     = sample_valid && (st == ARMED || st == POST);
    trig_hit  = st == ARMED && sample_valid && trigger;
    trig_ok   = trig_hit && fill >= p;
    rd_fire   = rd_req && st == DONE;
    rd_addr   = start_ptr + rd_idx;
    // DEPTH-1-p is the bitwise complement of p in ADDR_WIDTH bits
    post_init = {1'b0, ~p};
    post_last = st == POST && sample_valid && post_rem == (ADDR_WIDTH+1)'(1);
    st_nx     = arm_ok ? ARMED :
                trig_ok ? (post_init == '0 ? DONE : POST) :
                post_last ? DONE : st;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) st <= IDLE;
    else st <= st_nx;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= sample_data;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr     <= '0;
      fill       <= '0;
      p          <= '0;
      start_ptr  <= '0;
      post_rem   <= '0;
      trig_early <= 1'b0;
      vld        <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dq[i] <= '0;
    end else begin
      if (arm_ok) begin
        p    <= pretrig_len;
        fill <= '0;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (st == ARMED && sample_valid && fill < p) fill <= fill + 1'b1;
      if (trig_ok) begin
        start_ptr <= wr_ptr - p;
        post_rem  <= post_init;
      end
      if (st == POST && sample_valid) post_rem <= post_rem - 1'b1;
      trig_early <= arm_ok ? 1'b0 : trig_early | (trig_hit && fill < p);
      vld[0] <= rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) vld[i] <= vld[i-1];
      if (rd_fire) dq[0] <= mem[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) if (vld[i-1]) dq[i] <= dq[i-1];
    end
  assign state    = st;
  assign done     = st == DONE;
  assign rd_valid = vld[READ_LATENCY-1];
  assign rd_data  = dq[READ_LATENCY-1];
endmodule

// File: tb/tb_trace_capture_ram.sv
// tb_trace_capture_ram: scenario tasks drive captures and reads; a read scoreboard checks data and latency
module tb_trace_capture_ram;
  localparam int DW = 16, AW = 4, RL = 2, DEPTH = 16;
  logic clk = 0, resetn = 0, arm = 0, sample_valid = 0, trigger = 0, rd_req = 0;
  logic [AW-1:0] pretrig_len = '0, rd_idx = '0;
  logic [DW-1:0] sample_data = '0;
  logic [1:0] state;
  logic done, trig_early, rd_valid;
  logic [DW-1:0] rd_data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int exp_q[$], exp_t[$];

  trace_capture_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .pretrig_len(pretrig_len),
    .sample_valid(sample_valid), .sample_data(sample_data), .trigger(trigger),
    .state(state), .done(done), .trig_early(trig_early),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    int e, t;
    if (rd_valid === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0d at cycle %0d, required no read output", rd_data, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        if (rd_data !== 16'(e) || cyc !== t) begin
          n_fail++;
          $display("FAIL rd_data: got %0d at cycle %0d, required %0d at cycle %0d", rd_data, cyc, e, t);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int last);
    repeat (RL + 2) step;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reads_pending: got %0d outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_t.delete();
    n_chk++;
    if (rd_data !== 16'(last)) begin
      n_fail++;
      $display("FAIL rd_hold: got %0d, required %0d", rd_data, last);
    end
  endtask

  task automatic read_trace(input int base);
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1;
      rd_idx = i[AW-1:0];
      exp_q.push_back(base + i);
      exp_t.push_back(cyc + RL);
      step;
    end
    rd_req = 0;
    drain(base + DEPTH - 1);
  endtask

  task automatic capture(input int p, input int trig_k, input int early_k, input bit gaps, input int abort_k);
    int k, last, cycles;
    bit saw_post, phase;
    k = 0; cycles = 0; saw_post = 0; phase = 0;
    last = trig_k - p + DEPTH - 1;
    arm = 1;
    pretrig_len = p[AW-1:0];
    step;
    arm = 0;
    n_chk++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL arm_state: got %0d, required 1", state);
    end
    while (k <= last) begin
      if (cycles++ > 400) begin
        n_fail++;
        $display("FAIL capture_timeout: got %0d samples written, required %0d", k, last + 1);
        sample_valid = 0;
        trigger = 0;
        return;
      end
      phase = ~phase;
      if (gaps && !phase) begin
        sample_valid = 0;
        sample_data = 16'hbeef;
        trigger = (k == 7);
      end else begin
        sample_valid = 1;
        sample_data = k[DW-1:0];
        trigger = (k == trig_k || k == early_k);
      end
      step;
      if (sample_valid) begin
        if (state == 2'd2) saw_post = 1;
        if (k == abort_k) begin
          sample_valid = 0;
          trigger = 0;
          return;
        end
        k++;
      end
    end
    sample_valid = 0;
    trigger = 0;
    n_chk++;
    if (state !== 2'd3 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_after_last: got state=%0d done=%0d, required state=3 done=1", state, done);
    end
    n_chk++;
    if (trig_early !== (early_k >= 0)) begin
      n_fail++;
      $display("FAIL trig_early: got %0d, required %0d", trig_early, early_k >= 0);
    end
    n_chk++;
    if (saw_post !== (p != DEPTH - 1)) begin
      n_fail++;
      $display("FAIL post_visited: got %0d, required %0d", saw_post, p != DEPTH - 1);
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    step;
    step;
    n_chk++;
    if (state !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d done=%0d, required 0 0", state, done);
    end
    n_chk++;
    if (trig_early !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_trig_early: got %0d, required 0", trig_early);
    end
    n_chk++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_read: got valid=%0d data=%0d, required 0 0", rd_valid, rd_data);
    end
    resetn = 1;
    step;
  endtask

  task automatic test_basic;
    capture(4, 10, -1, 0, -1);
    read_trace(6);
  endtask

  task automatic test_back_to_back;
    int idx[3] = '{15, 0, 7};
    int ev[3] = '{21, 6, 13};
    for (int i = 0; i < 3; i++) begin
      rd_req = 1;
      rd_idx = idx[i][AW-1:0];
      exp_q.push_back(ev[i]);
      exp_t.push_back(cyc + RL);
      step;
    end
    rd_req = 1;
    rd_idx = 0;
    exp_q.push_back(6);
    exp_t.push_back(cyc + RL);
    step;
    rd_req = 0;
    arm = 1;
    pretrig_len = 3;
    step;
    arm = 0;
    n_chk++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL arm_in_flight: got state=%0d, required 3", state);
    end
    drain(6);
  endtask

  task automatic test_early_trigger;
    capture(4, 5, 2, 0, -1);
    read_trace(1);
  endtask

  task automatic test_p_zero;
    capture(0, 0, -1, 0, -1);
    read_trace(0);
  endtask

  task automatic test_p_max;
    capture(15, 20, -1, 0, -1);
    read_trace(5);
  endtask

  task automatic test_gaps;
    capture(4, 10, -1, 1, -1);
    read_trace(6);
  endtask

  task automatic test_reset_mid_post;
    capture(4, 10, -1, 0, 14);
    n_chk++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_post_state: got %0d, required 2", state);
    end
    rd_req = 1;
    rd_idx = 3;
    step;
    step;
    rd_req = 0;
    resetn = 0;
    #1;
    n_chk++;
    if (state !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got state=%0d done=%0d, required 0 0", state, done);
    end
    step;
    resetn = 1;
    repeat (4) step;
    capture(4, 10, -1, 0, -1);
    read_trace(6);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_early_trigger;
    test_p_zero;
    test_p_max;
    test_gaps;
    test_reset_mid_post;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
